// File: rtl/arb3_pkg.sv
// Shared types and grant-decoding helpers for the 3-input arbiter output buffer.
package arb3_pkg;

    localparam int NUM_IN         = 3;
    localparam int SRC_W          = 2;
    localparam int FLIT_W_DEFAULT = 16;

    typedef struct packed {
        logic [SRC_W-1:0]          src;
        logic [FLIT_W_DEFAULT-1:0] flit;
    } flit_entry_t;

    typedef struct packed {
        logic             vld;
        logic [SRC_W-1:0] idx;
    } grant_idx_t;

    function automatic logic is_onehot3(input logic [NUM_IN-1:0] g);
        return (g == 3'b001) || (g == 3'b010) || (g == 3'b100);
    endfunction

    function automatic grant_idx_t onehot3_to_idx(input logic [NUM_IN-1:0] g);
        grant_idx_t r;
        r.vld = is_onehot3(g);
        case (g)
            3'b001:  r.idx = 2'd0;
            3'b010:  r.idx = 2'd1;
            3'b100:  r.idx = 2'd2;
            default: r.idx = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arb3_fifo_mem.sv
// DEPTH x ENTRY_W register array: one enabled write port, one asynchronous read port.
module arb3_fifo_mem #(
    parameter  int ENTRY_W = 18,
    parameter  int DEPTH   = 4,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset; occupancy tracking lives in the parent.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we && (waddr == ADDR_W'(i))) begin
                mem[i] <= wdata;
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/arbiter3_out_buffer.sv
// Router output-port buffer behind a 3-input arbiter: grant-muxed write, valid/ready drain.
// Optional macro ARB3_OUTBUF_ALMOST_FULL_EN raises buffer_full_o one entry early.
module arbiter3_out_buffer
    import arb3_pkg::*;
#(
    parameter int FLIT_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               grant_i,
    input  logic                     grant_v_i,
    input  logic [FLIT_W-1:0]        flit0_i,
    input  logic [FLIT_W-1:0]        flit1_i,
    input  logic [FLIT_W-1:0]        flit2_i,
    output logic                     buffer_full_o,
    output logic [FLIT_W-1:0]        data_o,
    output logic [1:0]               src_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ALMOST_C = CNT_W'(DEPTH - 1);

    typedef struct packed {
        logic [SRC_W-1:0]  src;
        logic [FLIT_W-1:0] flit;
    } entry_t;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             err;

    grant_idx_t  sel;
    logic [FLIT_W-1:0] wflit;
    entry_t      wentry;
    entry_t      rentry;
    logic        store_full;
    logic        write_en;
    logic        pop;
    logic        nonempty;

    assign sel = onehot3_to_idx(grant_i);

    always_comb begin
        wflit = '0;
        case (sel.idx)
            2'd0:    wflit = flit0_i;
            2'd1:    wflit = flit1_i;
            2'd2:    wflit = flit2_i;
            default: wflit = '0;
        endcase
    end

    assign wentry.src  = sel.idx;
    assign wentry.flit = wflit;

    // Storage is truly full only at DEPTH; the early flag below is just advisory slack.
    assign store_full = (count == DEPTH_C);
    assign write_en   = grant_v_i && sel.vld && !store_full;
    assign nonempty   = (count != '0);
    assign pop        = nonempty && ready_i;

`ifdef ARB3_OUTBUF_ALMOST_FULL_EN
    assign buffer_full_o = (count >= ALMOST_C);
`else
    assign buffer_full_o = store_full;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (write_en) tail <= tail + PTR_W'(1);
            if (pop)      head <= head + PTR_W'(1);
            case ({write_en, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (grant_v_i && (!sel.vld || store_full)) err <= 1'b1;
        end
    end

    arb3_fifo_mem #(
        .ENTRY_W (SRC_W + FLIT_W),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (write_en),
        .waddr (tail),
        .wdata (wentry),
        .raddr (head),
        .rdata (rentry)
    );

    // Stale storage is masked so an empty buffer always presents zeros.
    assign valid_o = nonempty;
    assign data_o  = nonempty ? rentry.flit : '0;
    assign src_o   = nonempty ? rentry.src  : '0;
    assign count_o = count;
    assign err_o   = err;

endmodule

// File: tb/tb_arbiter3_out_buffer.sv
// Self-checking bench for arbiter3_out_buffer against a queue-based reference model.
module tb_arbiter3_out_buffer;

    localparam int FLIT_W = 16;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  grant;
    logic        grant_v;
    logic [15:0] f0, f1, f2;
    logic        ready;
    logic        buffer_full;
    logic [15:0] data;
    logic [1:0]  src;
    logic        valid;
    logic [2:0]  count;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] q[$];
    logic        m_err = 1'b0;

    arbiter3_out_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .grant_i       (grant),
        .grant_v_i     (grant_v),
        .flit0_i       (f0),
        .flit1_i       (f1),
        .flit2_i       (f2),
        .buffer_full_o (buffer_full),
        .data_o        (data),
        .src_o         (src),
        .valid_o       (valid),
        .ready_i       (ready),
        .count_o       (count),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    // One clock edge with the current inputs; the model follows the buffer's rules.
    task automatic tick();
        logic [15:0] flits [3];
        int  sz, s;
        bit  oh, acc, pp, r;
        flits = '{f0, f1, f2};
        sz  = q.size();
        oh  = ($countones(grant) == 1);
        s   = 0;
        for (int i = 0; i < 3; i++) if (grant[i]) s = i;
        acc = grant_v && oh && (sz < DEPTH);
        pp  = ready && (sz > 0);
        r   = rst;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back({2'(s), flits[s]});
            if (grant_v && !acc) m_err = 1'b1;
        end
        #1;
    endtask

    task automatic push(input int s, input logic [15:0] f);
        f0 = 16'($urandom); f1 = 16'($urandom); f2 = 16'($urandom);
        case (s)
            0: f0 = f;
            1: f1 = f;
            default: f2 = f;
        endcase
        grant   = 3'(1 << s);
        grant_v = 1'b1;
        tick();
        grant_v = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; grant_v = 1'b0; ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; grant = 3'b000; grant_v = 1'b0; ready = 1'b0;
        f0 = '0; f1 = '0; f2 = '0;
        tick(); tick();
        rst = 1'b0;
        n_checks++; if (count !== 3'd0)  begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
        n_checks++; if (buffer_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", buffer_full); end
        n_checks++; if (err !== 1'b0)    begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        n_checks++; if ({data, src} !== 18'd0) begin n_fail++; $display("FAIL reset_data got %h/%0d want 0/0", data, src); end
    endtask

    task automatic test_basic();
        push(1, 16'hBEEF);
        n_checks++; if (valid !== 1'b1)     begin n_fail++; $display("FAIL basic_valid got %b want 1", valid); end
        n_checks++; if (data !== 16'hBEEF)  begin n_fail++; $display("FAIL basic_data got %h want beef", data); end
        n_checks++; if (src !== 2'd1)       begin n_fail++; $display("FAIL basic_src got %0d want 1", src); end
        n_checks++; if (count !== 3'd1)     begin n_fail++; $display("FAIL basic_count got %0d want 1", count); end
        ready = 1'b1; tick(); ready = 1'b0;
        n_checks++; if (count !== 3'd0 || valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got count %0d valid %b want 0 0", count, valid); end
    endtask

    task automatic test_fill();
        int srcs [4] = '{0, 2, 1, 0};
        for (int i = 0; i < 4; i++) push(srcs[i], 16'(i + 1));
        n_checks++; if (count !== 3'd4)    begin n_fail++; $display("FAIL fill_count got %0d want 4", count); end
        n_checks++; if (buffer_full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b want 1", buffer_full); end
        n_checks++; if (err !== 1'b0)      begin n_fail++; $display("FAIL fill_err_early got %b want 0", err); end
        push(0, 16'h0005);
        n_checks++; if (err !== 1'b1 || count !== 3'd4) begin n_fail++; $display("FAIL fill_overflow got err %b count %0d want 1 4", err, count); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (data !== 16'(i + 1) || src !== 2'(srcs[i])) begin
                n_fail++; $display("FAIL fill_drain%0d got %h/%0d want %h/%0d", i, data, src, 16'(i + 1), srcs[i]);
            end
            ready = 1'b1; tick(); ready = 1'b0;
        end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL fill_empty got valid %b want 0", valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        push(2, 16'hA000);
        push(0, 16'hA001);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (data !== q[0][15:0] || src !== q[0][17:16]) begin
                n_fail++; $display("FAIL wrap_head%0d got %h/%0d want %h/%0d", i, data, src, q[0][15:0], q[0][17:16]);
            end
            ready = 1'b1;
            push($urandom_range(0, 2), 16'hA002 + 16'(i));
            ready = 1'b0;
            n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL wrap_count%0d got %0d want 2", i, count); end
        end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wrap_err got %b want 0", err); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 4; i++) push(i % 3, 16'hC000 + 16'(i));
        ready = 1'b1;
        push(1, 16'hCFFF);
        ready = 1'b0;
        n_checks++; if (count !== 3'd3)     begin n_fail++; $display("FAIL fullpop_count got %0d want 3", count); end
        n_checks++; if (err !== 1'b1)       begin n_fail++; $display("FAIL fullpop_err got %b want 1", err); end
        n_checks++; if (data !== 16'hC001)  begin n_fail++; $display("FAIL fullpop_head got %h want c001", data); end
    endtask

    task automatic test_illegal();
        logic [2:0] bad [4] = '{3'b011, 3'b000, 3'b111, 3'b101};
        do_reset();
        grant = 3'b011; grant_v = 1'b0; tick();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL illegal_ignored got err %b want 0", err); end
        for (int k = 0; k < 4; k++) begin
            do_reset();
            for (int i = 0; i < 3; i++) push(i, 16'hD000 + 16'(i));
            grant = bad[k]; grant_v = 1'b1; tick(); grant_v = 1'b0;
            n_checks++;
            if (err !== 1'b1 || count !== 3'd3) begin
                n_fail++; $display("FAIL illegal_%b got err %b count %0d want 1 3", bad[k], err, count);
            end
        end
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++;
        if (count !== 3'd0 || valid !== 1'b0 || err !== 1'b0 || buffer_full !== 1'b0) begin
            n_fail++; $display("FAIL illegal_midreset got count %0d valid %b err %b full %b want 0 0 0 0", count, valid, err, buffer_full);
        end
    endtask

    task automatic test_almost_full();
        do_reset();
        for (int i = 0; i < 3; i++) push(i, 16'hE000 + 16'(i));
`ifdef ARB3_OUTBUF_ALMOST_FULL_EN
        n_checks++; if (buffer_full !== 1'b1) begin n_fail++; $display("FAIL almost_full_at3 got %b want 1", buffer_full); end
`else
        n_checks++; if (buffer_full !== 1'b0) begin n_fail++; $display("FAIL full_at3 got %b want 0", buffer_full); end
`endif
        push(0, 16'hE003);
        n_checks++; if (count !== 3'd4 || err !== 1'b0) begin n_fail++; $display("FAIL fourth_write got count %0d err %b want 4 0", count, err); end
        push(1, 16'hE004);
        n_checks++; if (err !== 1'b1 || count !== 3'd4) begin n_fail++; $display("FAIL fifth_write got err %b count %0d want 1 4", err, count); end
    endtask

    task automatic test_random();
        logic [15:0] ed;
        logic [1:0]  es;
        logic        ef;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst     = ($urandom_range(0, 79) == 0);
            grant_v = ($urandom_range(0, 2) != 0);
            grant   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'(1 << $urandom_range(0, 2));
            f0 = 16'($urandom); f1 = 16'($urandom); f2 = 16'($urandom);
            ready   = ($urandom_range(0, 1) == 1);
            tick();
            ed = (q.size() > 0) ? q[0][15:0]  : 16'd0;
            es = (q.size() > 0) ? q[0][17:16] : 2'd0;
`ifdef ARB3_OUTBUF_ALMOST_FULL_EN
            ef = (q.size() >= DEPTH - 1);
`else
            ef = (q.size() == DEPTH);
`endif
            n_checks++; if (count !== 3'(q.size())) begin n_fail++; $display("FAIL rand_count c%0d got %0d want %0d", c, count, q.size()); end
            n_checks++; if (valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rand_valid c%0d got %b want %b", c, valid, q.size() > 0); end
            n_checks++; if (data !== ed) begin n_fail++; $display("FAIL rand_data c%0d got %h want %h", c, data, ed); end
            n_checks++; if (src !== es) begin n_fail++; $display("FAIL rand_src c%0d got %0d want %0d", c, src, es); end
            n_checks++; if (buffer_full !== ef) begin n_fail++; $display("FAIL rand_full c%0d got %b want %b", c, buffer_full, ef); end
            n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL rand_err c%0d got %b want %b", c, err, m_err); end
        end
        rst = 1'b0; grant_v = 1'b0; ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_wrap();
        test_full_pop();
        test_illegal();
        test_almost_full();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arbiter3_out_buffer.md
Name: arbiter3_out_buffer

Overview:
- Receiving end of the 3-input arbiter handshake in the router output port.
- Consumes the one-hot grant and grant-valid, and muxes the granted input's flit.
- Stores the flit with its 2-bit source index in a small FIFO and drains it downstream over valid/ready.
- Drives buffer_full_o back to the arbiter's buffer_full_i; its occupancy is the sole backpressure source.

Parameters:
- FLIT_W, 16, flit payload width in bits.
- DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
- clk, in, 1, clock, rising edge.
- rst, in, 1, reset; synchronous, active-high.
- grant_i, in, 3, one-hot grant from the arbiter.
- grant_v_i, in, 1, grant valid from the arbiter.
- flit0_i, in, FLIT_W, flit from input port 0.
- flit1_i, in, FLIT_W, flit from input port 1.
- flit2_i, in, FLIT_W, flit from input port 2.
- buffer_full_o, out, 1, backpressure to the arbiter.
- data_o, out, FLIT_W, head flit.
- src_o, out, 2, head flit's source index (0..2).
- valid_o, out, 1, head entry valid.
- ready_i, in, 1, downstream accepts the head this cycle.
- count_o, out, $clog2(DEPTH)+1, current occupancy.
- err_o, out, 1, sticky protocol-error flag.

Behaviour:
- Reset (rst high at a clock edge, including mid-traffic):
  - Head and tail pointers cleared, count_o=0, valid_o=0, buffer_full_o=0, err_o=0.
  - data_o and src_o read as 0 while empty.
  - Storage contents are not cleared.
- Write occurs when grant_v_i & onehot(grant_i) & !buffer_full_o.
  - Stores {src, flit} at the tail, where src = index of the set grant bit and flit = flit<src>_i.
  - Tail pointer advances mod DEPTH.
- Read (pop) occurs when valid_o & ready_i; head pointer advances mod DEPTH.
- Simultaneous write and read: count unchanged, both pointers advance.
- Write latency: a flit written at edge N is visible on data_o/valid_o after edge N. There is no same-cycle bypass from the flit inputs to data_o.
- Full is derived from the count register only:
  - buffer_full_o = (count == DEPTH).
  - There is no combinational path from ready_i to buffer_full_o. A pop in the same cycle does not free a slot for a write in that cycle.
- Empty: valid_o=0; ready_i is ignored.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; count distinguishes full from empty.
- Error cases set err_o (sticky until rst):
  - grant_v_i while buffer_full_o=1 → write dropped, err_o<=1.
  - grant_v_i with grant_i not one-hot (0 or more than one bit) → write dropped, err_o<=1.
- grant_i is ignored when grant_v_i=0.
- data_o, src_o and valid_o are driven from registered state only.

Optional Feature:
- Macro: ARB3_OUTBUF_ALMOST_FULL_EN.
- Defined: buffer_full_o = (count >= DEPTH-1).
  - Provides one cycle of slack for a registered upstream grant.
  - A write arriving while count == DEPTH-1 is still accepted and is not an error.
  - Only a write at count == DEPTH sets err_o.
- Undefined: buffer_full_o = (count == DEPTH), with behaviour exactly as above.

Decomposition:
- Package arb3_pkg holds:
  - NUM_IN = 3 and SRC_W = 2.
  - typedef flit_entry_t = struct {logic [1:0] src; logic [FLIT_W-1:0] flit}.
  - Function onehot3_to_idx (returns index plus validity).
  - Function is_onehot3.
- Sub-module arb3_fifo_mem: DEPTH x entry register array with one write port and one asynchronous read port. Built on the existing register primitive with per-entry enable.
- Pointer, count, full and error logic stay in the top module.

Test Plan (FLIT_W=16, DEPTH=4, macro undefined unless stated):
1. Basic write/read: grant_i=3'b010, grant_v_i=1, flit1_i=16'hBEEF, ready_i=0 for one cycle → next cycle valid_o=1, data_o=16'hBEEF, src_o=1, count_o=1. Then ready_i=1 → count_o=0, valid_o=0.
2. Fill: four writes with src 0, 2, 1, 0 and flits 16'h0001..16'h0004, ready_i=0 → count_o=4, buffer_full_o=1. A fifth grant_v_i → dropped, err_o=1, count_o stays 4. Drain returns 0001..0004 in order with src 0, 2, 1, 0.
3. Wrap and simultaneous access: hold count_o=2 and apply a write and ready_i=1 every cycle for 10 cycles → count_o stays 2, FIFO order preserved across pointer wrap, err_o=0.
4. Full with pop in the same cycle: count_o=4, ready_i=1 and grant_v_i=1 together → pop occurs, write dropped, err_o=1, count_o=3.
5. Illegal grant: grant_v_i=1 with grant_i=3'b011, then grant_i=3'b000 → no write, count_o unchanged, err_o=1. Assert rst mid-stream with count_o=3 → next cycle count_o=0, valid_o=0, err_o=0.
6. Macro defined: three writes → buffer_full_o=1 at count_o=3. A fourth write is accepted (count_o=4, err_o=0). A fifth write → err_o=1.
